// File: rtl/demux_1_3_buf_pkg.sv
// Shared types and encodings for the 1-to-3 registered demultiplexer.
package demux_1_3_buf_pkg;

  localparam int DEMUX_WIDTH = 32;

  localparam logic [1:0] SEL_CH0 = 2'd0;
  localparam logic [1:0] SEL_CH1 = 2'd1;
  localparam logic [1:0] SEL_CH2 = 2'd2;
  localparam logic [1:0] SEL_BAD = 2'd3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

  // One-hot channel strobe for a select value; SEL_BAD maps to no channel.
  function automatic logic [2:0] sel_decode(input logic [1:0] sel);
    logic [2:0] hot;
    hot = 3'b000;
    case (sel)
      SEL_CH0: hot = 3'b001;
      SEL_CH1: hot = 3'b010;
      SEL_CH2: hot = 3'b100;
      default: hot = 3'b000;
    endcase
    return hot;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// Single-entry valid/ready holding register for one demux output channel.
// state    | meaning
// ST_EMPTY | no word held, valid_out=0
// ST_FULL  | word held on data_out, valid_out=1
module demux_slot
  import demux_1_3_buf_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out,
  output logic             space
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A load wins over a drain in the same cycle: the register reloads.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = ST_FULL;
      data_d  = data_in;
    end else if (state_q == ST_FULL && ready_in) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid_out = (state_q == ST_FULL);
  assign data_out  = data_q;
  assign space     = !valid_out || ready_in;

endmodule

// File: rtl/demux_1_3_buf.sv
// Registered 1-to-3 demux with per-channel holding registers.
// Define DEMUX_ERR_EN to build the sticky illegal-select flag on err.
module demux_1_3_buf
  import demux_1_3_buf_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       sel,
  output logic             out_valid0,
  output logic             out_valid1,
  output logic             out_valid2,
  input  logic             out_ready0,
  input  logic             out_ready1,
  input  logic             out_ready2,
  output logic [WIDTH-1:0] dout0,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic             err
);

  logic [2:0] space;
  logic [2:0] load;
  logic       accept;

  always_comb begin
    in_ready = 1'b1;
    case (sel)
      SEL_CH0: in_ready = space[0];
      SEL_CH1: in_ready = space[1];
      SEL_CH2: in_ready = space[2];
      default: in_ready = 1'b1;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign load   = accept ? sel_decode(sel) : 3'b000;

  demux_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk(clk), .rst(rst), .load(load[0]), .data_in(din), .ready_in(out_ready0),
    .valid_out(out_valid0), .data_out(dout0), .space(space[0])
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk(clk), .rst(rst), .load(load[1]), .data_in(din), .ready_in(out_ready1),
    .valid_out(out_valid1), .data_out(dout1), .space(space[1])
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot2 (
    .clk(clk), .rst(rst), .load(load[2]), .data_in(din), .ready_in(out_ready2),
    .valid_out(out_valid2), .data_out(dout2), .space(space[2])
  );

`ifdef DEMUX_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q || (accept && sel == SEL_BAD);
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_demux_1_3_buf.sv
// Randomized and directed bench for demux_1_3_buf against a queue-based reference model.
module tb_demux_1_3_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] din = '0;
  logic [1:0]  sel = '0;
  logic        out_valid0, out_valid1, out_valid2;
  logic        out_ready0 = 1'b0, out_ready1 = 1'b0, out_ready2 = 1'b0;
  logic [31:0] dout0, dout1, dout2;
  logic        err;

  int errors = 0;
  int checks = 0;
  bit checking = 0;

  // Reference model: each channel is a FIFO of at most one word plus the last word shown.
  logic [31:0] mq[3][$];
  logic [31:0] mlast[3];
  bit          merr;

  always #5 clk = ~clk;

  demux_1_3_buf dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din), .sel(sel),
    .out_valid0(out_valid0), .out_valid1(out_valid1), .out_valid2(out_valid2),
    .out_ready0(out_ready0), .out_ready1(out_ready1), .out_ready2(out_ready2),
    .dout0(dout0), .dout1(dout1), .dout2(dout2), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_space(input int k, input bit rdy);
    return (mq[k].size() == 0) || rdy;
  endfunction

  // Drive one cycle of inputs, compare against the model, then advance the model.
  task automatic cycle(input bit r, input bit iv, input logic [31:0] d, input logic [1:0] s,
                       input bit r0, input bit r1, input bit r2, output bit acc);
    bit rdy[3];
    bit exp_ir;
    rdy[0] = r0; rdy[1] = r1; rdy[2] = r2;
    @(negedge clk);
    rst = r; in_valid = iv; din = d; sel = s;
    out_ready0 = r0; out_ready1 = r1; out_ready2 = r2;
    exp_ir = (s == 2'd3) ? 1'b1 : m_space(int'(s), rdy[s]);
    #1;
    if (checking) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
      chk("out_valid0", {31'd0, out_valid0}, {31'd0, mq[0].size() != 0});
      chk("out_valid1", {31'd0, out_valid1}, {31'd0, mq[1].size() != 0});
      chk("out_valid2", {31'd0, out_valid2}, {31'd0, mq[2].size() != 0});
      chk("dout0", dout0, (mq[0].size() != 0) ? mq[0][0] : mlast[0]);
      chk("dout1", dout1, (mq[1].size() != 0) ? mq[1][0] : mlast[1]);
      chk("dout2", dout2, (mq[2].size() != 0) ? mq[2][0] : mlast[2]);
      chk("err", {31'd0, err}, {31'd0, merr});
    end
    acc = iv && exp_ir;
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 3; k++) begin
        mq[k].delete();
        mlast[k] = '0;
      end
      merr = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (mq[k].size() != 0 && rdy[k]) mlast[k] = mq[k].pop_front();
        if (acc && int'(s) == k) mq[k].push_back(d);
      end
`ifdef DEMUX_ERR_EN
      if (acc && s == 2'd3) merr = 1'b1;
`endif
    end
  endtask

  initial begin
    bit acc;
    bit pend;
    bit r, iv, r0, r1, r2;
    logic [31:0] d;
    logic [1:0] s;
    merr = 1'b0;
    for (int k = 0; k < 3; k++) mlast[k] = '0;

    // 1. Reset held with a pending word, then released.
    cycle(1, 1, 32'hDEAD_BEEF, 2'd1, 0, 0, 0, acc);
    checking = 1;
    cycle(1, 1, 32'hDEAD_BEEF, 2'd1, 0, 0, 0, acc);
    cycle(1, 1, 32'hDEAD_BEEF, 2'd1, 0, 0, 0, acc);
    #2;
    chk("rst_valid1", {31'd0, out_valid1}, 32'd0);
    chk("rst_dout1", dout1, 32'd0);
    cycle(0, 1, 32'hDEAD_BEEF, 2'd1, 0, 0, 0, acc);
    #2;
    chk("first_valid1", {31'd0, out_valid1}, 32'd1);
    chk("first_dout1", dout1, 32'hDEAD_BEEF);
    cycle(0, 0, 32'h0, 2'd0, 0, 1, 0, acc);

    // 2. Streaming on channel 0.
    for (int i = 1; i <= 3; i++) begin
      cycle(0, 1, 32'(i), 2'd0, 1, 0, 0, acc);
      #2;
      chk("stream_dout0", dout0, 32'(i));
    end
    cycle(0, 0, 32'h0, 2'd0, 1, 0, 0, acc);

    // 3. Backpressure on channel 2, channel 1 unaffected.
    cycle(0, 1, 32'hA, 2'd2, 0, 0, 0, acc);
    cycle(0, 1, 32'hB, 2'd2, 0, 0, 0, acc);
    chk("bp_blocked", {31'd0, acc}, 32'd0);
    cycle(0, 1, 32'hC, 2'd1, 0, 0, 0, acc);
    chk("bp_other_acc", {31'd0, acc}, 32'd1);
    cycle(0, 1, 32'hB, 2'd2, 0, 0, 1, acc);
    chk("bp_release_acc", {31'd0, acc}, 32'd1);
    #2;
    chk("bp_dout2", dout2, 32'hB);

    // 4. Channel 0 full and stalled, channel 1 still accepts.
    cycle(0, 1, 32'h44, 2'd0, 0, 1, 1, acc);
    cycle(0, 1, 32'h55, 2'd1, 0, 1, 0, acc);
    #2;
    chk("ind_dout1", dout1, 32'h55);
    chk("ind_dout0", dout0, 32'h44);

    // 5. Illegal select.
    cycle(0, 1, 32'h77, 2'd3, 0, 0, 0, acc);
    chk("bad_acc", {31'd0, acc}, 32'd1);
    cycle(0, 0, 32'h0, 2'd0, 0, 0, 0, acc);
    cycle(0, 0, 32'h0, 2'd0, 0, 0, 0, acc);

    // 6. Reset mid-operation with channels 0 and 2 full.
    cycle(0, 1, 32'h99, 2'd2, 0, 0, 0, acc);
    cycle(1, 0, 32'h0, 2'd0, 0, 0, 0, acc);
    #2;
    chk("mid_rst_valid0", {31'd0, out_valid0}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    cycle(0, 1, 32'h1234_5678, 2'd2, 0, 0, 0, acc);
    cycle(0, 0, 32'h0, 2'd0, 0, 0, 0, acc);

    // Random traffic; an unaccepted word is held until it goes through.
    pend = 0; d = '0; s = '0;
    for (int n = 0; n < 2000; n++) begin
      r  = ($urandom_range(99) == 0);
      r0 = ($urandom_range(3) != 0);
      r1 = ($urandom_range(1) != 0);
      r2 = ($urandom_range(4) == 0);
      if (!pend) begin
        iv = ($urandom_range(3) != 0);
        d  = $urandom;
        s  = 2'($urandom_range(3));
      end else begin
        iv = 1'b1;
      end
      cycle(r, iv, d, s, r0, r1, r2, acc);
      pend = iv && !acc && !r;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
